branch_predict_ctrl: RTL and testbench

Sequences the pipeline's branch resolution path. Predicts conditional branches in fetch using a PC-indexed table of 2-bit saturating counters. Compares the EX-stage branch unit outcome (pc_src) against the carried prediction, and issues the flush and redirect PC on a mispredict. Keeps retired-branch and mispredict statistics counters.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_history_table.sv | 38 +++
 rtl/branch_predict_ctrl.sv | 94 +++++++++
 tb/tb_branch_predict_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch prediction/resolution path.
//   bht_state_t : 2-bit saturating counter state (SNT, WNT, WT, ST)
//   BHT_INIT    : state every table entry takes on reset
//   PC_STEP     : byte distance to the sequential next instruction
//   bht_next()  : saturating counter update for one resolved branch
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t  BHT_INIT = WNT;
  localparam int unsigned PC_STEP  = 4;

  // Move one step towards the observed outcome, holding at either end.
  function automatic bht_state_t bht_next(bht_state_t cur, logic taken);
    bht_state_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = bht_state_t'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt = bht_state_t'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters indexed by PC bits.
//   clk_i, rst_i  : clock and synchronous active-high reset (entries -> BHT_INIT)
//   rd_idx_i      : asynchronous read index (fetch)
//   rd_state_o    : counter state at rd_idx_i, pre-update value on a same-cycle write
//   we_i          : apply one resolved-branch update at the next rising edge
//   wr_idx_i      : index of the entry to update
//   wr_taken_i    : resolved direction, moves the counter up (1) or down (0)
module branch_history_table
  import branch_pkg::*;
#(
  parameter  int unsigned BHT_ENTRIES = 64,
  localparam int unsigned INDEX_BITS  = $clog2(BHT_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output bht_state_t            rd_state_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  wr_taken_i
);

  bht_state_t table_q [BHT_ENTRIES];

  // No write-to-read bypass: fetch sees the stored value.
  assign rd_state_o = table_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        table_q[i] <= BHT_INIT;
      end
    end else if (we_i) begin
      table_q[wr_idx_i] <= bht_next(table_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction and resolution control.
//   clk, rst                        : clock, synchronous active-high reset
//   fetch_valid/is_branch/pc/imm    : fetch-stage instruction for prediction
//   predict_taken, predict_target   : combinational fetch prediction
//   ex_valid/stall/is_cond/is_jump  : EX-stage instruction qualifiers
//   ex_pc, ex_pred_taken            : EX PC and the prediction carried with it
//   ex_pc_src, ex_target            : resolved outcome and target
//   flush, redirect_pc              : one-cycle kill/redirect on a mispredict
//   branch_count, mispredict_count  : wrapping statistics counters
module branch_predict_ctrl
  import branch_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned BHT_ENTRIES = 64,
  localparam int unsigned INDEX_BITS  = $clog2(BHT_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic                  fetch_is_branch,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  input  logic [DATA_WIDTH-1:0] fetch_imm,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] predict_target,
  input  logic                  ex_valid,
  input  logic                  ex_stall,
  input  logic                  ex_is_cond,
  input  logic                  ex_is_jump,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_pred_taken,
  input  logic                  ex_pc_src,
  input  logic [DATA_WIDTH-1:0] ex_target,
  output logic                  flush,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] branch_count,
  output logic [DATA_WIDTH-1:0] mispredict_count
);

  logic                  live;
  logic                  jump_ev;
  logic                  cond_ev;
  logic                  mispredict;
  logic                  actual_taken;
  bht_state_t            fetch_state;
  logic [DATA_WIDTH-1:0] ex_pc_next;
  logic [DATA_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [DATA_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  branch_history_table #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk_i      (clk),
    .rst_i      (rst),
    .rd_idx_i   (fetch_pc[INDEX_BITS+1:2]),
    .rd_state_o (fetch_state),
    .we_i       (cond_ev),
    .wr_idx_i   (ex_pc[INDEX_BITS+1:2]),
    .wr_taken_i (ex_pc_src)
  );

  // Prediction is forced low during reset since the table is about to be reinitialised.
  assign predict_taken  = fetch_valid & fetch_is_branch & fetch_state[1] & ~rst;
  assign predict_target = fetch_pc + fetch_imm;

  always_comb begin
    live         = ex_valid & ~ex_stall & ~rst;
    jump_ev      = live & ex_is_jump;
    // A jump dominates if both flags are set, so the table is left alone.
    cond_ev      = live & ex_is_cond & ~ex_is_jump;
    mispredict   = jump_ev | (cond_ev & (ex_pc_src != ex_pred_taken));
    actual_taken = ex_pc_src | ex_is_jump;
    ex_pc_next   = ex_pc + DATA_WIDTH'(PC_STEP);

    flush       = mispredict;
    redirect_pc = (mispredict & actual_taken) ? ex_target : ex_pc_next;

    branch_count_d     = branch_count_q + DATA_WIDTH'(cond_ev);
    mispredict_count_d = mispredict_count_q + DATA_WIDTH'(mispredict);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid, fetch_is_branch;
  logic [DW-1:0] fetch_pc, fetch_imm;
  logic          predict_taken;
  logic [DW-1:0] predict_target;
  logic          ex_valid, ex_stall, ex_is_cond, ex_is_jump, ex_pred_taken, ex_pc_src;
  logic [DW-1:0] ex_pc, ex_target;
  logic          flush;
  logic [DW-1:0] redirect_pc, branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predict_ctrl #(
    .DATA_WIDTH  (32),
    .BHT_ENTRIES (64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_is_branch  (fetch_is_branch),
    .fetch_pc         (fetch_pc),
    .fetch_imm        (fetch_imm),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_is_cond       (ex_is_cond),
    .ex_is_jump       (ex_is_jump),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pc_src        (ex_pc_src),
    .ex_target        (ex_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as integers 0..3 (>=2 means taken), plain event counts.
  int unsigned   m_bht [64];
  logic [DW-1:0] m_branches, m_mispredicts;
  bit            m_ready = 1'b0;

  function automatic bit m_live();
    return ex_valid && !ex_stall && !rst;
  endfunction

  function automatic bit m_flush();
    return m_live() && (ex_is_jump || (ex_is_cond && (ex_pc_src != ex_pred_taken)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_bht[i] <= 1;
      m_branches    <= '0;
      m_mispredicts <= '0;
      m_ready       <= 1'b1;
    end else if (m_live()) begin
      if (m_flush()) m_mispredicts <= m_mispredicts + 1;
      if (ex_is_cond && !ex_is_jump) begin
        m_branches <= m_branches + 1;
        if (ex_pc_src) m_bht[ex_pc[7:2]] <= (m_bht[ex_pc[7:2]] == 3) ? 3 : m_bht[ex_pc[7:2]] + 1;
        else           m_bht[ex_pc[7:2]] <= (m_bht[ex_pc[7:2]] == 0) ? 0 : m_bht[ex_pc[7:2]] - 1;
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_ready) begin
      logic          exp_pt;
      logic          exp_fl;
      logic [DW-1:0] exp_rd;
      exp_pt = !rst && fetch_valid && fetch_is_branch && (m_bht[fetch_pc[7:2]] >= 2);
      exp_fl = m_flush();
      exp_rd = (exp_fl && (ex_is_jump || ex_pc_src)) ? ex_target : ex_pc + 32'd4;
      check("model predict_taken", {31'd0, predict_taken}, {31'd0, exp_pt});
      check("model predict_target", predict_target, fetch_pc + fetch_imm);
      check("model flush", {31'd0, flush}, {31'd0, exp_fl});
      check("model redirect_pc", redirect_pc, exp_rd);
      check("model branch_count", branch_count, m_branches);
      check("model mispredict_count", mispredict_count, m_mispredicts);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic br, input logic [DW-1:0] pc,
                           input logic [DW-1:0] imm);
    fetch_valid = v; fetch_is_branch = br; fetch_pc = pc; fetch_imm = imm;
  endtask

  task automatic set_ex(input logic v, input logic stall, input logic cond, input logic jump,
                        input logic [DW-1:0] pc, input logic pred, input logic src,
                        input logic [DW-1:0] tgt);
    ex_valid = v; ex_stall = stall; ex_is_cond = cond; ex_is_jump = jump;
    ex_pc = pc; ex_pred_taken = pred; ex_pc_src = src; ex_target = tgt;
  endtask

  task automatic ex_idle();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    set_fetch(1'b0, 1'b0, 32'h0, 32'h0);
    ex_idle();
    step();
    step();
    rst = 1'b0;

    // Reset state and first prediction.
    set_fetch(1'b1, 1'b1, 32'h100, 32'h20);
    #1;
    check("reset predict_taken", {31'd0, predict_taken}, 32'd0);
    check("reset predict_target", predict_target, 32'h120);
    check("reset branch_count", branch_count, 32'd0);
    check("reset mispredict_count", mispredict_count, 32'd0);

    // Three taken resolutions at 0x100: only the first mispredicts.
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h180);
    #1;
    check("taken1 flush", {31'd0, flush}, 32'd1);
    check("taken1 redirect", redirect_pc, 32'h180);
    step();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h180);
    #1;
    check("taken2 flush", {31'd0, flush}, 32'd0);
    step();
    step();
    ex_idle();
    #1;
    check("trained predict_taken", {31'd0, predict_taken}, 32'd1);
    check("after taken branch_count", branch_count, 32'd3);
    check("after taken mispredict_count", mispredict_count, 32'd1);

    // Predicted taken, resolved not-taken.
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h260);
    #1;
    check("nt flush", {31'd0, flush}, 32'd1);
    check("nt redirect", redirect_pc, 32'h204);
    step();
    ex_idle();
    #1;
    check("nt mispredict_count", mispredict_count, 32'd2);

    // jal: always flush, no table or branch_count effect.
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 32'h400);
    #1;
    check("jal flush", {31'd0, flush}, 32'd1);
    check("jal redirect", redirect_pc, 32'h400);
    step();
    ex_idle();
    #1;
    check("jal branch_count", branch_count, 32'd4);
    check("jal mispredict_count", mispredict_count, 32'd3);

    // Stalled mispredicting branch resolves once when the stall drops.
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 1'b0, 1'b1, 32'h340);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall flush", {31'd0, flush}, 32'd0);
      step();
    end
    ex_stall = 1'b0;
    #1;
    check("unstall flush", {31'd0, flush}, 32'd1);
    check("unstall redirect", redirect_pc, 32'h340);
    step();
    ex_idle();
    #1;
    check("unstall branch_count", branch_count, 32'd5);
    check("unstall mispredict_count", mispredict_count, 32'd4);

    // Same-cycle fetch read and update of index 5: no bypass.
    set_fetch(1'b1, 1'b1, 32'h14, 32'h8);
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 1'b0, 1'b1, 32'h1c);
    #1;
    check("idx5 same-cycle predict", {31'd0, predict_taken}, 32'd0);
    step();
    ex_idle();
    #1;
    check("idx5 next-cycle predict", {31'd0, predict_taken}, 32'd1);

    // Back-to-back mispredicts give back-to-back flushes.
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0, 32'h0);
    step();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h504, 1'b0, 1'b0, 32'h800);
    #1;
    check("b2b second flush", {31'd0, flush}, 32'd1);
    step();
    ex_idle();
    #1;
    check("b2b mispredict_count", mispredict_count, 32'd7);

    // Pseudo-random mix checked by the model each cycle.
    for (int i = 0; i < 80; i++) begin
      logic c;
      logic j;
      c = 1'($urandom_range(0, 1));
      j = !c && ($urandom_range(0, 4) == 0);
      set_fetch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'h1000 + {$urandom_range(0, 7), 2'b00}, $urandom);
      set_ex(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), c, j,
             32'h1000 + {$urandom_range(0, 7), 2'b00}, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom);
      step();
    end

    // Reset mid-stream with a live mispredict presented.
    set_fetch(1'b1, 1'b1, 32'h100, 32'h20);
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h180);
    rst = 1'b1;
    #1;
    check("rst predict_taken", {31'd0, predict_taken}, 32'd0);
    check("rst flush", {31'd0, flush}, 32'd0);
    step();
    rst = 1'b0;
    ex_idle();
    #1;
    check("post-rst predict 0x100", {31'd0, predict_taken}, 32'd0);
    check("post-rst branch_count", branch_count, 32'd0);
    check("post-rst mispredict_count", mispredict_count, 32'd0);
    set_fetch(1'b1, 1'b1, 32'h14, 32'h0);
    #1;
    check("post-rst predict idx5", {31'd0, predict_taken}, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
